instr_fetch: RTL

Instruction fetch unit for the single-cycle-read instruction memory. Drives a 6-bit word address to the memory, captures the returned 32-bit instruction together with its PC into a small prefetch queue, and presents fetched instructions to decode over a valid/ready handshake. Supports a PC redirect from branch/jump resolution, with queue flush. An optional halt is raised on an all-zero instruction word.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_queue.sv | 70 +++++++
 rtl/instr_fetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared widths, halt word and fetch queue entry type for the CPU front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;

    // Fetching this word stops the front end when halt detection is built in.
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: synchronous FIFO of fetch entries with flush; head is zero when empty.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_push, i_push_dat    write request and entry
//   i_pop                 remove head (ignored when empty)
//   i_flush               empty the queue; wins over push
//   o_full, o_empty       occupancy flags
//   o_head                head entry, all-zero when empty
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_dat,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // A full queue may still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Purpose: instruction fetch; drives the PC to imem, queues {pc, instr}, hands them to decode.
// Latency: 1 cycle fetch-to-decode; redirect costs a 2-cycle bubble.
// Backpressure: out_ready low fills the queue, then PC holds until the head is taken.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_addr / imem_instr          PC to memory, same-cycle read data back
//   redirect_valid / redirect_addr  load new PC, flush queue
//   out_valid / out_ready           decode handshake
//   out_instr / out_pc              head entry (zero when empty)
//   halted                          fetch stopped on the halt word
// Build option: IFETCH_HALT_ZERO_EN enables halt on the all-zero word;
// without it the zero word is fetched like any other and halted is 0.
module instr_fetch #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int QDEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    import cpu_pkg::fetch_entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    fetch_entry_t      w_push_dat;
    fetch_entry_t      w_head;

    assign imem_addr  = r_pc;
    assign w_push_dat = {r_pc, imem_instr};
    assign w_pop      = out_valid && out_ready;

`ifdef IFETCH_HALT_ZERO_EN
    import cpu_pkg::HALT_WORD;

    logic r_halted;
    logic w_fetch_ok;
    logic w_is_halt;

    assign w_fetch_ok = !redirect_valid && !r_halted && (!w_full || w_pop);
    assign w_is_halt  = (imem_instr == HALT_WORD);
    // The halt word itself is never queued; PC stays parked on it.
    assign w_push     = w_fetch_ok && !w_is_halt;
    assign halted     = r_halted;

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_fetch_ok && w_is_halt) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_push = !redirect_valid && (!w_full || w_pop);
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_addr;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // Redirect flushes the queue; a head popped in that same cycle is simply lost.
    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    assign out_valid = !w_empty;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule
